// File: rtl/serial_tx_pkg.sv
// Shared types and helpers for the serial pattern transmitter.
package serial_tx_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  // A length of zero, or one beyond the word width, means "send the full word".
  function automatic int clamp_len(input int len, input int w);
    return ((len == 0) || (len > w)) ? w : len;
  endfunction

endpackage

// File: rtl/seq_matcher.sv
// Reference model of a Mealy sequence detector wired straight to x:
// history register, overlapping comparator and saturating hit counter.
module seq_matcher #(
  parameter int              TLEN   = 4,
  parameter logic [TLEN-1:0] TARGET = 4'b1011,
  parameter int              CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          x,
  output logic          exp_z,
  output logic [CW-1:0] hit_cnt
);

  if (TARGET == '0) begin : g_bad_target
    $error("seq_matcher: TARGET must not be all zeros");
  end

  logic [TLEN-2:0] hist_reg;
  logic [TLEN-1:0] window;
  logic [TLEN-1:0] bit_match;
  logic [CW-1:0]   hit_cnt_reg;

  assign window = {hist_reg, x};

  for (genvar gi = 0; gi < TLEN; gi++) begin : g_cmp
    assign bit_match[gi] = window[gi] ~^ TARGET[gi];
  end

  assign exp_z   = &bit_match;
  assign hit_cnt = hit_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_reg    <= '0;
      hit_cnt_reg <= '0;
    end else begin
      hist_reg <= window[TLEN-2:0];
      if (exp_z && (hit_cnt_reg != '1)) begin
        hit_cnt_reg <= hit_cnt_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Loads a word over valid/ready and shifts it out MSB-first on x, with an
// optional idle gap after each word and an expected-detector-output model.
module serial_pattern_tx
  import serial_tx_pkg::*;
#(
  parameter int              W      = 16,
  parameter int              LW     = $clog2(W + 1),
  parameter int              GAP    = 0,
  parameter int              TLEN   = 4,
  parameter logic [TLEN-1:0] TARGET = 4'b1011,
  parameter int              CW     = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic [W-1:0]  load_data,
  input  logic [LW-1:0] load_len,
  output logic          x,
  output logic          x_valid,
  output logic          busy,
  output logic          done,
  output logic          exp_z,
  output logic [CW-1:0] hit_cnt
);

  localparam int GW = 8;
  localparam logic [GW-1:0] GAP_LAST = (GAP > 0) ? GW'(GAP - 1) : '0;

  state_t        state_reg, state_next;
  logic [W-1:0]  shift_reg;
  logic [LW-1:0] len_reg;
  logic [LW-1:0] bit_cnt_reg;
  logic [GW-1:0] gap_cnt_reg;
  logic          done_reg;
  logic [LW-1:0] len_clamped;
  logic          last_bit;

  assign len_clamped = LW'(clamp_len(int'(load_len), W));
  assign last_bit    = (state_reg == S_SHIFT) && (bit_cnt_reg == len_reg - 1'b1);
  assign done        = done_reg;

  always_comb begin
    state_next = state_reg;
    load_ready = 1'b0;
    x          = 1'b0;
    x_valid    = 1'b0;
    busy       = (state_reg != S_IDLE);
    case (state_reg)
      S_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) state_next = S_SHIFT;
      end
      S_SHIFT: begin
        x       = shift_reg[W-1];
        x_valid = 1'b1;
        if (last_bit) state_next = (GAP > 0) ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        if (gap_cnt_reg == GAP_LAST) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The word is left-aligned on load so the first bit to send sits in the MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      shift_reg   <= '0;
      len_reg     <= '0;
      bit_cnt_reg <= '0;
      gap_cnt_reg <= '0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      done_reg  <= last_bit;
      case (state_reg)
        S_IDLE: begin
          if (load_valid) begin
            shift_reg   <= load_data << (W - int'(len_clamped));
            len_reg     <= len_clamped;
            bit_cnt_reg <= '0;
          end
        end
        S_SHIFT: begin
          shift_reg   <= shift_reg << 1;
          bit_cnt_reg <= bit_cnt_reg + 1'b1;
          gap_cnt_reg <= '0;
        end
        S_GAP: gap_cnt_reg <= gap_cnt_reg + 1'b1;
        default: ;
      endcase
    end
  end

  seq_matcher #(
    .TLEN  (TLEN),
    .TARGET(TARGET),
    .CW    (CW)
  ) u_matcher (
    .clk    (clk),
    .rst    (rst),
    .x      (x),
    .exp_z  (exp_z),
    .hit_cnt(hit_cnt)
  );

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

Serial bit-stream transmitter that drives the single-bit `x` input of the team's Mealy sequence detectors. It accepts a parallel word of programmable length over a valid/ready handshake and shifts it out MSB-first, one bit per clock. It also produces a cycle-exact expected detector output `exp_z` and a saturating hit count for a parameterised target sequence, so benches and on-chip self-test can check the detector directly.

## Interface
- `W`, 16: maximum word length in bits (≥2).
- `LW`, `$clog2(W+1)`: width of `load_len`.
- `GAP`, 0: idle cycles inserted after each word (0..255).
- `TLEN`, 4: target sequence length (2..W).
- `TARGET`, 4'b1011: target sequence, first bit in MSB; all-zero is illegal (elaboration error).
- `CW`, 8: hit counter width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `load_valid` in 1: word offered.
- `load_ready` out 1: transmitter can accept a word.
- `load_data` in W: word; bits `[len-1:0]` are sent, bit `len-1` first.
- `load_len` in LW: number of bits; 0 or >W is treated as W.
- `x` out 1: serial data, 0 when not transmitting.
- `x_valid` out 1: `x` carries a word bit this cycle.
- `busy` out 1: state ≠ IDLE.
- `done` out 1: one-cycle pulse after a word's last bit.
- `exp_z` out 1: expected Mealy detector output for the current `x`.
- `hit_cnt` out CW: count of `exp_z` cycles, saturating.

## Operation
- FSM states: IDLE, SHIFT, GAP.
- IDLE: `load_ready`=1. When `load_valid`&`load_ready` are high at an edge, latch data and clamped length, clear the bit counter, and go to SHIFT.
- SHIFT: `x`=current MSB of the shift register and `x_valid`=1. Shift left each cycle. After the cycle carrying bit 0, go to GAP if GAP>0, else IDLE.
- GAP: `x`=0, `x_valid`=0 for exactly GAP cycles, then IDLE.
- `load_ready` is 0 in SHIFT and GAP. A `load_valid` held during busy is not accepted and waits.
- Matcher: a history register `hist[TLEN-2:0]` shifts in `x` on every clock, including idle zeros, so it models a detector wired straight to `x`.
  - `exp_z` = ({hist, x} == TARGET), combinational, in the same cycle as the matching bit. Overlapping matches are detected.
- `hit_cnt` increments on each cycle with `exp_z`=1 and holds at 2^CW−1.
- Reset, including mid-word: at the next edge, state=IDLE, word dropped, `hist`=0, `hit_cnt`=0, `done`=0.

## Timing
- Reset values: `x`=0, `x_valid`=0, `busy`=0, `done`=0, `exp_z`=0, `hit_cnt`=0, `load_ready`=1.
- Latency: the first bit appears on `x` the cycle after the accepting edge. A word of L bits occupies L cycles of `x_valid`.
- `done` is high in the cycle after the last bit, which is the first GAP or IDLE cycle.
- With GAP=0, the next word can be accepted in that `done` cycle. Throughput is L+1 cycles per word, and the single idle 0 enters `hist`.
- `x`, `x_valid`, `busy`, `done`, `load_ready` and `hit_cnt` are registered/state-decoded. `exp_z` is combinational from `hist` and `x`.

## Structure
- Package `serial_tx_pkg`: state enum typedef (IDLE/SHIFT/GAP) and a length-clamp function.
- Sub-module `seq_matcher`: parameters TLEN, TARGET, CW; inputs clk, rst, x; outputs exp_z, hit_cnt. Contains the history register, comparator and saturating counter.
- Top level: FSM, shift register, bit counter and gap counter.

## Test plan
All scenarios use W=16, TLEN=4, TARGET=4'b1011, GAP=0 unless stated.
- Reset: hold `rst` 2 cycles → all outputs at reset values, `load_ready`=1.
- Single word: `load_data`=8'b1011_0110, `load_len`=8.
  - `x` = 1,0,1,1,0,1,1,0 on cycles 1–8 after accept.
  - `exp_z` high on bits 4 and 7; `hit_cnt`=2.
  - `done` pulses on cycle 9.
- Back-to-back across the idle bit: word A = 3'b101 (len 3), accepted in A's `done` cycle by word B = 2'b11 (len 2).
  - `x` stream is 1,0,1,0,1,1.
  - `exp_z` high only on B's second bit; `hit_cnt`=1.
- Length clamp: `load_len`=0, `load_data`=16'hFFFF → 16 cycles of `x_valid`=1, `exp_z` never high, `done` on cycle 17.
- Reset mid-word: 8-bit word, `rst` asserted during bit 3 → next cycle `x`=0, `x_valid`=0, `busy`=0, `load_ready`=1, `hit_cnt`=0, no `done`.
- Busy hold-off and saturation:
  - `load_valid` held high through a 16-bit word → second word accepted only in the `done` cycle.
  - With CW=2, repeated 4'b1011 words → `hit_cnt` stops at 3.
